alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Execute-to-writeback pipeline register directly downstream of the ALU. Captures the ALU
//  result, the 3-bit ALU flag vector and the destination register, and resolves the branch
//  condition. Holds a sticky carry register for carry-conditional branches. Uses a
//  valid/ready handshake toward the register-file writeback stage.
// PARAMETERS
//  WIDTH  32  datapath width (ALU result, branch target, wb_data)
//  RADDR  5   register-file address width
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      upstream holds a valid ALU result this cycle
//  in_ready    out  1      stage can accept; transfer when in_valid & in_ready
//  alu_out     in   WIDTH  ALU result
//  alu_flag    in   3      [0] rs==0, [1] rs<0, [2] carry from add
//  carry_we    in   1      instruction is add-class; update carry register from alu_flag[2]
//  rd_addr     in   RADDR  destination register
//  rd_we       in   1      instruction writes a register
//  br_cond     in   3      0 none,1 br,2 bltz,3 bz,4 bnz,5 bcy,6 bncy,7 reserved(=none)
//  br_target   in   WIDTH  branch target address
//  out_valid   out  1      stage holds a valid entry
//  out_ready   in   1      downstream accepts; transfer when out_valid & out_ready
//  wb_data     out  WIDTH  registered ALU result
//  wb_addr     out  RADDR  registered destination
//  wb_en       out  1      registered rd_we, qualified by out_valid
//  br_taken    out  1      registered branch decision, qualified by out_valid
//  br_pc       out  WIDTH  registered br_target
//  carry_q     out  1      sticky carry register
// BEHAVIOUR
//  - Reset: out_valid=0, wb_data=0, wb_addr=0, wb_en=0, br_taken=0, br_pc=0, carry_q=0.
//    Reset in mid-transfer discards the held entry; no stale writeback after rst.
//  - States: EMPTY (out_valid=0), FULL (out_valid=1). in_ready = ~out_valid | out_ready.
//  - EMPTY: in_valid -> capture, go FULL next cycle. Latency in->out = 1 cycle.
//  - FULL: out_ready & in_valid -> replace entry same edge, stay FULL (full throughput);
//    out_ready & ~in_valid -> EMPTY; ~out_ready -> hold all outputs stable, in_ready=0.
//  - Capture only on in_valid & in_ready; outputs never change while out_valid & ~out_ready.
//  - Branch decision computed at capture from incoming flags and carry value in effect:
//    br 1; bltz alu_flag[1]; bz alu_flag[0]; bnz ~alu_flag[0]; bcy c; bncy ~c; 0/7 -> 0.
//    c = carry_q before this capture (a branch never sees its own carry_we).
//  - carry_q <= alu_flag[2] on capture when carry_we=1; otherwise unchanged. Not updated on
//    stalled/unaccepted inputs.
//  - wb_en = out_valid & registered rd_we; br_taken output = out_valid & registered decision.
//  - rd_addr==0 passes through unchanged; write suppression to r0 is downstream's job.
//  - No arithmetic in this stage; all widths pass through unmodified.
// TESTING
//  1 rst=1 for 2 cycles with in_valid=1 -> all outputs 0, out_valid=0, carry_q=0.
//  2 alu_out=0x0000_0005,rd_addr=3,rd_we=1,in_valid=1,out_ready=1 -> next cycle out_valid=1,
//    wb_data=5,wb_addr=3,wb_en=1; back-to-back inputs 6,7 appear on consecutive cycles.
//  3 out_ready=0 while FULL, new inputs offered -> in_ready=0, wb_data held 5 for N cycles;
//    out_ready=1 -> next queued input captured, no loss or duplication.
//  4 add with alu_flag=3'b100,carry_we=1, then bcy br_target=0x40 -> carry_q=1,
//    br_taken=1, br_pc=0x40; then add flag[2]=0 carry_we=1, bncy -> br_taken=1.
//  5 bz with alu_flag[0]=1 -> br_taken=1; bnz same flags -> 0; bltz alu_flag[1]=1 -> 1;
//    br_cond=7 -> 0.
//  6 FULL with out_ready=0, assert rst one cycle -> out_valid=0, wb_en=0 next cycle.

Source files
------------

// File: rtl/alu_result_stage.sv
// Execute-to-writeback pipeline register: captures the ALU result, resolves the branch
// condition against the sticky carry, and hands off over a valid/ready handshake.
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [2:0]       alu_flag,
  input  logic             carry_we,
  input  logic [RADDR-1:0] rd_addr,
  input  logic             rd_we,
  input  logic [2:0]       br_cond,
  input  logic [WIDTH-1:0] br_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [RADDR-1:0] wb_addr,
  output logic             wb_en,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_pc,
  output logic             carry_q
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state;
  logic   capture;
  logic   br_dec;

  assign out_valid = (state == FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign capture   = in_valid & in_ready;

  // Branch sees carry_q as it stands before this capture, never its own carry_we.
  always_comb begin
    br_dec = 1'b0;
    unique case (br_cond)
      3'd1:    br_dec = 1'b1;
      3'd2:    br_dec = alu_flag[1];
      3'd3:    br_dec = alu_flag[0];
      3'd4:    br_dec = ~alu_flag[0];
      3'd5:    br_dec = carry_q;
      3'd6:    br_dec = ~carry_q;
      default: br_dec = 1'b0;
    endcase
  end

  // wb_en and br_taken are kept pre-qualified so they read 0 whenever the stage is EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      wb_data  <= '0;
      wb_addr  <= '0;
      wb_en    <= 1'b0;
      br_taken <= 1'b0;
      br_pc    <= '0;
      carry_q  <= 1'b0;
    end else if (capture) begin
      state    <= FULL;
      wb_data  <= alu_out;
      wb_addr  <= rd_addr;
      wb_en    <= rd_we;
      br_taken <= br_dec;
      br_pc    <= br_target;
      if (carry_we) carry_q <= alu_flag[2];
    end else if (state == FULL && out_ready) begin
      state    <= EMPTY;
      wb_en    <= 1'b0;
      br_taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and random stimulus for alu_result_stage, checked against a queue-based scoreboard.
module tb_alu_result_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned RADDR = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_out;
  logic [2:0]       alu_flag;
  logic             carry_we;
  logic [RADDR-1:0] rd_addr;
  logic             rd_we;
  logic [2:0]       br_cond;
  logic [WIDTH-1:0] br_target;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] wb_data;
  logic [RADDR-1:0] wb_addr;
  logic             wb_en;
  logic             br_taken;
  logic [WIDTH-1:0] br_pc;
  logic             carry_q;

  alu_result_stage #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_flag(alu_flag), .carry_we(carry_we),
    .rd_addr(rd_addr), .rd_we(rd_we), .br_cond(br_cond), .br_target(br_target),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data),
    .wb_addr(wb_addr), .wb_en(wb_en), .br_taken(br_taken), .br_pc(br_pc),
    .carry_q(carry_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [RADDR-1:0] addr;
    logic             en;
    logic             taken;
    logic [WIDTH-1:0] pc;
  } entry_t;

  entry_t q[$];
  logic   model_c;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_br(input logic [2:0] bc, input logic [2:0] f, input logic c);
    case (bc)
      3'd1:    return 1'b1;
      3'd2:    return f[1];
      3'd3:    return f[0];
      3'd4:    return ~f[0];
      3'd5:    return c;
      3'd6:    return ~c;
      default: return 1'b0;
    endcase
  endfunction

  // Called at a negedge: drive inputs, check outputs against scoreboard, update model, clock.
  task automatic cyc(input logic iv, input logic ordy, input logic [WIDTH-1:0] data,
                     input logic [RADDR-1:0] addr, input logic we, input logic [2:0] flag,
                     input logic cwe, input logic [2:0] bc, input logic [WIDTH-1:0] tgt);
    logic   exp_valid;
    logic   exp_ready;
    entry_t e;
    in_valid = iv; out_ready = ordy; alu_out = data; rd_addr = addr; rd_we = we;
    alu_flag = flag; carry_we = cwe; br_cond = bc; br_target = tgt;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = !exp_valid || ordy;
    chk("out_valid", WIDTH'(out_valid), WIDTH'(exp_valid));
    chk("in_ready", WIDTH'(in_ready), WIDTH'(exp_ready));
    chk("carry_q", WIDTH'(carry_q), WIDTH'(model_c));
    if (exp_valid) begin
      e = q[0];
      chk("wb_data", wb_data, e.data);
      chk("wb_addr", WIDTH'(wb_addr), WIDTH'(e.addr));
      chk("wb_en", WIDTH'(wb_en), WIDTH'(e.en));
      chk("br_taken", WIDTH'(br_taken), WIDTH'(e.taken));
      chk("br_pc", br_pc, e.pc);
      if (ordy) void'(q.pop_front());
    end else begin
      chk("wb_en_idle", WIDTH'(wb_en), '0);
      chk("br_taken_idle", WIDTH'(br_taken), '0);
    end
    if (iv && exp_ready) begin
      e.data = data; e.addr = addr; e.en = we; e.pc = tgt;
      e.taken = model_br(bc, flag, model_c);
      q.push_back(e);
      if (cwe) model_c = flag[2];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; alu_out = 32'hDEAD_BEEF;
    rd_addr = 5'd9; rd_we = 1'b1; alu_flag = 3'b111; carry_we = 1'b1;
    br_cond = 3'd1; br_target = 32'h1234;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", WIDTH'(out_valid), '0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_wb_addr", WIDTH'(wb_addr), '0);
    chk("rst_wb_en", WIDTH'(wb_en), '0);
    chk("rst_br_taken", WIDTH'(br_taken), '0);
    chk("rst_br_pc", br_pc, '0);
    chk("rst_carry_q", WIDTH'(carry_q), '0);
    q.delete();
    model_c = 1'b0;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    model_c = 1'b0;
    do_reset(2);

    // Pass-through and back-to-back throughput
    cyc(1, 1, 32'd5, 5'd3, 1, 3'b000, 0, 3'd0, 32'h0);
    cyc(1, 1, 32'd6, 5'd4, 1, 3'b000, 0, 3'd0, 32'h0);
    cyc(1, 1, 32'd7, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);
    cyc(0, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);
    cyc(0, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);

    // Stall: offered inputs with carry_we must not be taken or touch carry
    cyc(1, 1, 32'd5, 5'd3, 1, 3'b000, 0, 3'd0, 32'h0);
    repeat (4) cyc(1, 0, 32'd8, 5'd8, 1, 3'b100, 1, 3'd1, 32'h88);
    cyc(1, 1, 32'd8, 5'd8, 1, 3'b100, 1, 3'd1, 32'h88);
    cyc(0, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);
    cyc(0, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);

    // Carry-conditional branches
    cyc(1, 1, 32'd1, 5'd1, 1, 3'b000, 1, 3'd0, 32'h0);
    cyc(1, 1, 32'd2, 5'd1, 1, 3'b100, 1, 3'd0, 32'h0);
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd5, 32'h40);
    cyc(1, 1, 32'd3, 5'd2, 1, 3'b000, 1, 3'd0, 32'h0);
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd6, 32'h44);
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b100, 1, 3'd5, 32'h48);
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b000, 1, 3'd6, 32'h4C);

    // Flag-conditional branches
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b001, 0, 3'd3, 32'h50);
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b001, 0, 3'd4, 32'h54);
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b010, 0, 3'd2, 32'h58);
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd2, 32'h5C);
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b111, 0, 3'd7, 32'h60);
    cyc(1, 1, 32'd0, 5'd0, 0, 3'b111, 0, 3'd1, 32'h64);
    cyc(0, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);
    cyc(0, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);

    // Reset while FULL and stalled
    cyc(1, 1, 32'hAA, 5'd7, 1, 3'b100, 1, 3'd1, 32'h70);
    cyc(0, 0, 32'd0, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);
    do_reset(1);
    cyc(0, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);

    // Random handshake traffic
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom,
          RADDR'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
          3'($urandom), $urandom);
    repeat (3) cyc(0, 1, 32'd0, 5'd0, 0, 3'b000, 0, 3'd0, 32'h0);
    chk("scoreboard_drained", WIDTH'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
